iq_detector: RTL and testbench

Receive-side counterpart of the DDS stimulus path. Takes one ADC channel and the DDS cos/sin reference words, removes the ADC offset, and multiplies the sample by each reference. It accumulates the I and Q products over a programmed number of valid samples and presents the sums to the frequency-response readout logic through a valid/ready handshake.

---
 rtl/iq_detector_pkg.sv | 23 ++
 rtl/iq_mac.sv | 98 +++++++++
 rtl/iq_detector.sv | 180 ++++++++++++++++++
 tb/tb_iq_detector.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/iq_detector_pkg.sv
// Shared definitions for the I/Q detector: FSM encoding, ADC offset removal
// and the accumulator width rule.
package iq_detector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // XOR into the sample MSB turns offset binary into two's complement.
  localparam logic ADC_OFFSET_FLIP = 1'b1;

  // Headroom above a single product so that 2^32 products can never overflow.
  localparam int ACC_GUARD_BITS = 32;

  function automatic bit acc_width_ok(input int dac_w, input int adc_w, input int acc_w);
    return acc_w >= (dac_w + adc_w + ACC_GUARD_BITS);
  endfunction

endpackage

// File: rtl/iq_mac.sv
// Three-stage multiply-accumulate: offset removal and reference capture,
// signed I/Q products, then accumulation into clearable sums.
module iq_mac
  import iq_detector_pkg::*;
#(
  parameter int DAC_WIDTH = 14,
  parameter int ADC_WIDTH = 12,
  parameter int ACC_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic        [ADC_WIDTH-1:0] sample,
  input  logic signed [DAC_WIDTH-1:0] ref_cos,
  input  logic signed [DAC_WIDTH-1:0] ref_sin,
  output logic                        s1_busy,
  output logic signed [ACC_WIDTH-1:0] i_total,
  output logic signed [ACC_WIDTH-1:0] q_total
);

  localparam int PW = DAC_WIDTH + ADC_WIDTH;

  logic                        s1_valid_r;
  logic signed [ADC_WIDTH-1:0] s1_sample_r;
  logic signed [DAC_WIDTH-1:0] s1_cos_r;
  logic signed [DAC_WIDTH-1:0] s1_sin_r;
  logic                        s2_valid_r;
  logic signed [PW-1:0]        s2_i_r;
  logic signed [PW-1:0]        s2_q_r;
  logic signed [ACC_WIDTH-1:0] i_acc_r;
  logic signed [ACC_WIDTH-1:0] q_acc_r;

  assign s1_busy = s1_valid_r;

  // S1: signed sample and matching references
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_r  <= 1'b0;
      s1_sample_r <= '0;
      s1_cos_r    <= '0;
      s1_sin_r    <= '0;
    end else if (clear) begin
      s1_valid_r  <= 1'b0;
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sample_r <= {sample[ADC_WIDTH-1] ^ ADC_OFFSET_FLIP, sample[ADC_WIDTH-2:0]};
        s1_cos_r    <= ref_cos;
        s1_sin_r    <= ref_sin;
      end
    end
  end

  // S2: full-precision signed products
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_valid_r <= 1'b0;
      s2_i_r     <= '0;
      s2_q_r     <= '0;
    end else if (clear) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_i_r <= PW'(s1_sample_r) * PW'(s1_cos_r);
        s2_q_r <= PW'(s1_sample_r) * PW'(s1_sin_r);
      end
    end
  end

  // S3 adder: totals already include the product sitting in S2, so the
  // caller can capture a complete result one cycle before the pipe empties.
  always_comb begin
    if (s2_valid_r) begin
      i_total = i_acc_r + ACC_WIDTH'(s2_i_r);
      q_total = q_acc_r + ACC_WIDTH'(s2_q_r);
    end else begin
      i_total = i_acc_r;
      q_total = q_acc_r;
    end
  end

  // S3 accumulator registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      i_acc_r <= '0;
      q_acc_r <= '0;
    end else if (clear) begin
      i_acc_r <= '0;
      q_acc_r <= '0;
    end else begin
      i_acc_r <= i_total;
      q_acc_r <= q_total;
    end
  end

endmodule

// File: rtl/iq_detector.sv
// I/Q detector top: parameter latching, measurement FSM and counters around
// the iq_mac pipeline, with a valid/ready result interface.
module iq_detector
  import iq_detector_pkg::*;
#(
  parameter int DAC_WIDTH = 14,
  parameter int ADC_WIDTH = 12,
  parameter int ACC_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ref_rdy,
  input  logic signed [DAC_WIDTH-1:0] ref_cos,
  input  logic signed [DAC_WIDTH-1:0] ref_sin,
  input  logic        [ADC_WIDTH-1:0] adc_data_1,
  input  logic        [ADC_WIDTH-1:0] adc_data_2,
  input  logic                        param_wen,
  input  logic        [31:0]          acc_len,
  input  logic        [31:0]          settle_len,
  input  logic        [31:0]          ch_sel,
  input  logic                        start,
  output logic                        busy,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic signed [ACC_WIDTH-1:0] i_sum,
  output logic signed [ACC_WIDTH-1:0] q_sum,
  output logic        [31:0]          sample_cnt
);

  if (!acc_width_ok(DAC_WIDTH, ADC_WIDTH, ACC_WIDTH)) begin : g_acc_width_check
    $error("iq_detector: ACC_WIDTH too small for DAC_WIDTH+ADC_WIDTH+32");
  end

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic        [31:0]          acc_len_r;
  logic        [31:0]          settle_len_r;
  logic                        ch_sel_r;
  logic        [31:0]          settle_cnt_r;
  logic        [31:0]          issue_cnt_r;
  logic        [31:0]          acc_target_s;
  logic                        settle_done_s;
  logic                        issue_s;
  logic                        issue_last_s;
  logic                        clear_s;
  logic                        s1_busy_s;
  logic        [ADC_WIDTH-1:0] sample_s;
  logic signed [ACC_WIDTH-1:0] i_total_s;
  logic signed [ACC_WIDTH-1:0] q_total_s;
  logic                        unused_ch_sel_s;

  assign unused_ch_sel_s = ^ch_sel[31:1];

  assign acc_target_s = (acc_len_r == 32'd0) ? 32'd1 : acc_len_r;
  assign issue_s      = (state_r == ST_ACCUM) && ref_rdy;
  assign issue_last_s = ((issue_cnt_r + 32'd1) == acc_target_s);
  assign clear_s      = (state_r == ST_IDLE) && start;
  assign sample_s     = ch_sel_r ? adc_data_2 : adc_data_1;

  // Settle ends after max(settle_len,1) cycles
  always_comb begin
    if (settle_len_r == 32'd0) begin
      settle_done_s = 1'b1;
    end else begin
      settle_done_s = (({1'b0, settle_cnt_r} + 33'd1) >= {1'b0, settle_len_r});
    end
  end

  // Parameter registers, writable only while idle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_len_r    <= 32'd0;
      settle_len_r <= 32'd0;
      ch_sel_r     <= 1'b0;
    end else if ((state_r == ST_IDLE) && param_wen) begin
      acc_len_r    <= acc_len;
      settle_len_r <= settle_len;
      ch_sel_r     <= ch_sel[0];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_SETTLE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (settle_done_s) state_nxt_s = ST_ACCUM;
        else               state_nxt_s = ST_SETTLE;
      end
      ST_ACCUM: begin
        if (issue_s && issue_last_s) state_nxt_s = ST_DRAIN;
        else                         state_nxt_s = ST_ACCUM;
      end
      // Leave once S1 is empty; the last product is still in S2 but is
      // folded into the captured totals.
      ST_DRAIN: begin
        if (!s1_busy_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (result_ready) state_nxt_s = ST_IDLE;
        else              state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Settle and issue counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      settle_cnt_r <= 32'd0;
      issue_cnt_r  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          settle_cnt_r <= 32'd0;
          issue_cnt_r  <= 32'd0;
        end
        ST_SETTLE: settle_cnt_r <= settle_cnt_r + 32'd1;
        ST_ACCUM: begin
          if (issue_s) issue_cnt_r <= issue_cnt_r + 32'd1;
        end
        default: begin
          settle_cnt_r <= settle_cnt_r;
          issue_cnt_r  <= issue_cnt_r;
        end
      endcase
    end
  end

  // Registered status and result outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy         <= 1'b0;
      result_valid <= 1'b0;
      i_sum        <= '0;
      q_sum        <= '0;
      sample_cnt   <= 32'd0;
    end else begin
      busy         <= (state_nxt_s != ST_IDLE);
      result_valid <= (state_nxt_s == ST_DONE);
      if ((state_r == ST_DRAIN) && (state_nxt_s == ST_DONE)) begin
        i_sum      <= i_total_s;
        q_sum      <= q_total_s;
        sample_cnt <= issue_cnt_r;
      end
    end
  end

  iq_mac #(
    .DAC_WIDTH (DAC_WIDTH),
    .ADC_WIDTH (ADC_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear_s),
    .in_valid (issue_s),
    .sample   (sample_s),
    .ref_cos  (ref_cos),
    .ref_sin  (ref_sin),
    .s1_busy  (s1_busy_s),
    .i_total  (i_total_s),
    .q_total  (q_total_s)
  );

endmodule

// File: tb/tb_iq_detector.sv
// Directed plus randomized bench for iq_detector; expected sums come from
// plain arithmetic over the samples the bench presents during ACCUM.
module tb_iq_detector;

  localparam int DW = 14;
  localparam int AW = 12;
  localparam int CW = 64;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 ref_rdy;
  logic signed [DW-1:0] ref_cos;
  logic signed [DW-1:0] ref_sin;
  logic        [AW-1:0] adc_data_1;
  logic        [AW-1:0] adc_data_2;
  logic                 param_wen;
  logic        [31:0]   acc_len;
  logic        [31:0]   settle_len;
  logic        [31:0]   ch_sel;
  logic                 start;
  logic                 busy;
  logic                 result_valid;
  logic                 result_ready;
  logic signed [CW-1:0] i_sum;
  logic signed [CW-1:0] q_sum;
  logic        [31:0]   sample_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iq_detector #(.DAC_WIDTH(DW), .ADC_WIDTH(AW), .ACC_WIDTH(CW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ref_rdy      (ref_rdy),
    .ref_cos      (ref_cos),
    .ref_sin      (ref_sin),
    .adc_data_1   (adc_data_1),
    .adc_data_2   (adc_data_2),
    .param_wen    (param_wen),
    .acc_len      (acc_len),
    .settle_len   (settle_len),
    .ch_sel       (ch_sel),
    .start        (start),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .i_sum        (i_sum),
    .q_sum        (q_sum),
    .sample_cnt   (sample_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint sval(input logic [AW-1:0] a);
    return longint'(a) - longint'(1 << (AW - 1));
  endfunction

  // One measurement: program, start, feed, wait for result, hold, handshake.
  // rdy_mode: 0 = always ready, 1 = 1,0,1,0 from first ACCUM cycle, else random.
  task automatic run_meas(input string name, input int n, input int s, input bit ch,
                          input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic signed [DW-1:0] cs, input logic signed [DW-1:0] sn,
                          input bit rnd_data, input int rdy_mode, input bit poke);
    int     neff;
    int     settle;
    int     taken;
    int     c;
    int     w;
    longint smp;
    longint exp_i;
    longint exp_q;
    neff   = (n == 0) ? 1 : n;
    settle = (s == 0) ? 1 : s;
    exp_i  = 0;
    exp_q  = 0;
    taken  = 0;
    c      = 0;
    acc_len    = 32'(n);
    settle_len = 32'(s);
    ch_sel     = ($urandom() & 32'hFFFF_FFFE) | 32'(ch);
    adc_data_1 = a1;
    adc_data_2 = a2;
    ref_cos    = cs;
    ref_sin    = sn;
    ref_rdy    = 1'b0;
    param_wen  = 1'b1;
    start      = 1'b1;
    step();
    param_wen  = 1'b0;
    start      = 1'b0;
    chk({name, ":busy_after_start"}, 64'(busy), 64'd1);
    while (taken < neff && c < 4000) begin
      c++;
      if (rnd_data) begin
        adc_data_1 = AW'($urandom());
        adc_data_2 = AW'($urandom());
        ref_cos    = DW'($urandom());
        ref_sin    = DW'($urandom());
      end
      case (rdy_mode)
        0:       ref_rdy = 1'b1;
        1:       ref_rdy = (c > settle) ? (((c - settle) % 2) == 1) : 1'b0;
        default: ref_rdy = 1'($urandom_range(0, 1));
      endcase
      if (poke && c == 2) begin
        param_wen = 1'b1;
        acc_len   = 32'd8;
      end else begin
        param_wen = 1'b0;
      end
      if (c > settle && ref_rdy) begin
        smp   = ch ? sval(adc_data_2) : sval(adc_data_1);
        exp_i += smp * longint'(ref_cos);
        exp_q += smp * longint'(ref_sin);
        taken++;
      end
      step();
    end
    ref_rdy   = 1'b0;
    param_wen = 1'b0;
    w = 0;
    while (result_valid !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    chk({name, ":drain_latency"}, 64'(w), 64'd2);
    chk({name, ":result_valid"}, 64'(result_valid), 64'd1);
    chk({name, ":i_sum"}, i_sum, exp_i);
    chk({name, ":q_sum"}, q_sum, exp_q);
    chk({name, ":sample_cnt"}, 64'(sample_cnt), 64'(neff));
    chk({name, ":busy_done"}, 64'(busy), 64'd1);
    // Result must hold while unacknowledged, even with start pulses and new data
    for (int k = 0; k < 3; k++) begin
      start      = 1'b1;
      ref_rdy    = 1'($urandom_range(0, 1));
      adc_data_1 = AW'($urandom());
      ref_cos    = DW'($urandom());
      step();
      chk({name, ":hold_valid"}, 64'(result_valid), 64'd1);
      chk({name, ":hold_i"}, i_sum, exp_i);
    end
    start        = 1'b0;
    ref_rdy      = 1'b0;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({name, ":valid_after_ack"}, 64'(result_valid), 64'd0);
    chk({name, ":busy_after_ack"}, 64'(busy), 64'd0);
    chk({name, ":q_after_ack"}, q_sum, exp_q);
    chk({name, ":cnt_after_ack"}, 64'(sample_cnt), 64'(neff));
  endtask

  initial begin
    rstn         = 1'b0;
    ref_rdy      = 1'b0;
    ref_cos      = '0;
    ref_sin      = '0;
    adc_data_1   = '0;
    adc_data_2   = '0;
    param_wen    = 1'b0;
    acc_len      = 32'd0;
    settle_len   = 32'd0;
    ch_sel       = 32'd0;
    start        = 1'b0;
    result_ready = 1'b0;
    step();
    step();
    chk("reset:busy", 64'(busy), 64'd0);
    chk("reset:result_valid", 64'(result_valid), 64'd0);
    chk("reset:i_sum", i_sum, 64'd0);
    chk("reset:q_sum", q_sum, 64'd0);
    chk("reset:sample_cnt", 64'(sample_cnt), 64'd0);
    rstn = 1'b1;
    step();

    run_meas("basic", 4, 0, 1'b0, 12'd2148, 12'd0, 14'sd1000, -14'sd500, 1'b0, 0, 1'b0);
    run_meas("midscale", 16, 0, 1'b0, 12'd2048, 12'd123, DW'($urandom()), DW'($urandom()),
             1'b0, 0, 1'b0);
    run_meas("ch2_extreme", 2, 0, 1'b1, 12'd4095, 12'd0, 14'sd8191, 14'h2000, 1'b0, 0, 1'b0);
    run_meas("toggle_rdy", 4, 0, 1'b0, 12'd2148, 12'd0, 14'sd1000, -14'sd500, 1'b0, 1, 1'b0);
    run_meas("acc_len_zero", 0, 2, 1'b0, 12'd3000, 12'd0, -14'sd77, 14'sd4001, 1'b0, 0, 1'b0);
    run_meas("param_while_busy", 4, 1, 1'b0, 12'd1000, 12'd0, 14'sd321, -14'sd999, 1'b1, 2, 1'b1);

    // Abort mid-ACCUM with a one-cycle reset
    acc_len    = 32'd100;
    settle_len = 32'd0;
    ch_sel     = 32'd0;
    adc_data_1 = 12'd3000;
    ref_cos    = 14'sd500;
    ref_sin    = 14'sd500;
    ref_rdy    = 1'b1;
    param_wen  = 1'b1;
    start      = 1'b1;
    step();
    param_wen  = 1'b0;
    start      = 1'b0;
    repeat (5) step();
    rstn = 1'b0;
    step();
    chk("abort:busy", 64'(busy), 64'd0);
    chk("abort:result_valid", 64'(result_valid), 64'd0);
    chk("abort:i_sum", i_sum, 64'd0);
    chk("abort:q_sum", q_sum, 64'd0);
    rstn    = 1'b1;
    ref_rdy = 1'b0;
    step();
    chk("abort:idle_busy", 64'(busy), 64'd0);
    run_meas("after_abort", 5, 0, 1'b0, 12'd0, 12'd0, 14'sd0, 14'sd0, 1'b1, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run_meas("random", $urandom_range(0, 20), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
               12'd0, 12'd0, 14'sd0, 14'sd0, 1'b1, 2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
